// File: rtl/mcu_pipe.sv
// -----------------------------------------------------------------------------
// mcu_pipe -- main control unit for the edge-detection datapath.
//
// Sequences one window of work at a time: SRAM pixel reads, grayscale
// conversion, buffer-1 fill, gradient compute, buffer-2 save and SRAM writes.
// Pixel, output-word and window counts are kept internally, so the datapath
// does not need to report buffer-full, buffer-empty or frame-done itself.
// After the first window of a frame only REFILL_CNT new pixels are read
// (sliding window). A stop request is honoured only at the two settle points,
// so a read or write that has started always runs to completion.
//
// Parameters
//   FILL_CNT     pixels read for the first window of a frame (>= 1)
//   REFILL_CNT   pixels read for each later window (1..FILL_CNT)
//   OUT_CNT      buffer-2 words written per window (>= 1)
//   FRAME_W      width of the windows-per-frame value and window counter
//   TIMEOUT_CYC  watchdog limit in cycles (only with MCU_PIPE_TIMEOUT_EN)
//
// Ports
//   clk, n_rst               clock; asynchronous active-low reset
//   i_stop                   hold idle / stop at the next safe point
//   i_frame_windows          windows per frame, sampled at frame start
//   i_raddr_ready .. i_write_complete   datapath handshakes
//   o_inc_raddr .. o_we      one-cycle registered command pulses
//   o_busy                   high whenever the FSM is not idle
//   o_frame_done             pulse after the last write of the last window
//   o_error                  watchdog expiry (0 unless MCU_PIPE_TIMEOUT_EN)
//
// Build option
//   `define MCU_PIPE_TIMEOUT_EN adds a per-state watchdog and the ERROR state.
// -----------------------------------------------------------------------------
module mcu_pipe #(
    parameter int FILL_CNT    = 9,
    parameter int REFILL_CNT  = 3,
    parameter int OUT_CNT     = 1,
    parameter int FRAME_W     = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               i_stop,
    input  logic [FRAME_W-1:0] i_frame_windows,
    input  logic               i_raddr_ready,
    input  logic               i_read_complete,
    input  logic               i_grayscale_data_ready,
    input  logic               i_gradient_data_ready,
    input  logic               i_start_next_write,
    input  logic               i_waddr_ready,
    input  logic               i_write_complete,
    output logic               o_inc_raddr,
    output logic               o_re,
    output logic               o_grayscale_start,
    output logic               o_b1_save,
    output logic               o_b1_clear,
    output logic               o_gradient_start,
    output logic               o_b2_save,
    output logic               o_inc_waddr,
    output logic               o_we,
    output logic               o_busy,
    output logic               o_frame_done,
    output logic               o_error
);

    // Reject parameter sets the sequencing cannot honour.
    if (FILL_CNT < 1 || REFILL_CNT < 1 || REFILL_CNT > FILL_CNT ||
        OUT_CNT < 1 || FRAME_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("mcu_pipe: illegal parameter combination");
    end

    localparam int PIX_W = $clog2(FILL_CNT + 1);
    localparam int OUT_W = $clog2(OUT_CNT + 1);

    localparam logic [PIX_W-1:0] FILL_V   = PIX_W'(FILL_CNT);
    localparam logic [PIX_W-1:0] REFILL_V = PIX_W'(REFILL_CNT);
    localparam logic [OUT_W-1:0] OUT_V    = OUT_W'(OUT_CNT);

    // Without overlap every window starts from an empty buffer 1.
    localparam bit NO_OVERLAP = (REFILL_CNT == FILL_CNT);

    typedef enum logic [4:0] {
        IDLE,
        RD_INC,
        RD_AWAIT,
        RD_EN,
        RD_WAIT,
        GRAY_START,
        GRAY_WAIT,
        B1_SAVE,
        B1_SETTLE,
        EDGE_START,
        EDGE_WAIT,
        B2_SAVE,
        WR_GATE,
        WR_INC,
        WR_AWAIT,
        WR_EN,
        WR_WAIT,
        WR_SETTLE,
        FRAME_DONE
`ifdef MCU_PIPE_TIMEOUT_EN
        , ERROR
`endif
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_settle;        // second cycle of a settle state
    logic [PIX_W-1:0]     r_pix_cnt;
    logic [OUT_W-1:0]     r_out_cnt;
    logic [FRAME_W-1:0]   r_win_cnt;
    logic [FRAME_W-1:0]   r_frame_windows;

    logic                 w_start;
    logic                 w_in_settle;
    logic                 w_stop_exit;
    logic                 w_win_done;
    logic                 w_last_win;
    logic [PIX_W-1:0]     w_pix_target;

    logic                 r_inc_raddr;
    logic                 r_re;
    logic                 r_grayscale_start;
    logic                 r_b1_save;
    logic                 r_b1_clear;
    logic                 r_gradient_start;
    logic                 r_b2_save;
    logic                 r_inc_waddr;
    logic                 r_we;
    logic                 r_busy;
    logic                 r_frame_done;

    assign w_start      = (r_state == IDLE) && !i_stop;
    assign w_in_settle  = (r_state == B1_SETTLE) || (r_state == WR_SETTLE);
    assign w_stop_exit  = w_in_settle && r_settle && i_stop;
    assign w_win_done   = (r_state == WR_SETTLE) && r_settle && !i_stop &&
                          (r_out_cnt >= OUT_V);
    // r_frame_windows is never 0, so the subtraction cannot wrap.
    assign w_last_win   = (r_win_cnt >= r_frame_windows - FRAME_W'(1));
    assign w_pix_target = (r_win_cnt == '0) ? FILL_V : REFILL_V;

`ifdef MCU_PIPE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_wait_state;
    logic            r_error;

    assign w_wait_state = r_state inside {RD_AWAIT, RD_WAIT, GRAY_WAIT, EDGE_WAIT,
                                         WR_GATE, WR_AWAIT, WR_WAIT};
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns w_next -- no latch inferred.
        w_next = r_state;
        case (r_state)
            IDLE:       if (!i_stop)                w_next = RD_INC;
            RD_INC:                                 w_next = RD_AWAIT;
            RD_AWAIT:   if (i_raddr_ready)          w_next = RD_EN;
            RD_EN:                                  w_next = RD_WAIT;
            RD_WAIT:    if (i_read_complete)        w_next = GRAY_START;
            GRAY_START:                             w_next = GRAY_WAIT;
            GRAY_WAIT:  if (i_grayscale_data_ready) w_next = B1_SAVE;
            B1_SAVE:                                w_next = B1_SETTLE;
            B1_SETTLE: begin
                if (r_settle) begin
                    if (i_stop)                     w_next = IDLE;
                    else if (r_pix_cnt < w_pix_target) w_next = RD_INC;
                    else                            w_next = EDGE_START;
                end
            end
            EDGE_START:                             w_next = EDGE_WAIT;
            EDGE_WAIT:  if (i_gradient_data_ready)  w_next = B2_SAVE;
            B2_SAVE:                                w_next = WR_GATE;
            WR_GATE:    if (i_start_next_write)     w_next = WR_INC;
            WR_INC:                                 w_next = WR_AWAIT;
            WR_AWAIT:   if (i_waddr_ready)          w_next = WR_EN;
            WR_EN:                                  w_next = WR_WAIT;
            WR_WAIT:    if (i_write_complete)       w_next = WR_SETTLE;
            WR_SETTLE: begin
                if (r_settle) begin
                    if (i_stop)                     w_next = IDLE;
                    else if (r_out_cnt < OUT_V)     w_next = WR_GATE;
                    else if (w_last_win)            w_next = FRAME_DONE;
                    else                            w_next = RD_INC;
                end
            end
            FRAME_DONE:                             w_next = IDLE;
`ifdef MCU_PIPE_TIMEOUT_EN
            ERROR:      if (i_stop)                 w_next = IDLE;
`endif
            default:                                w_next = IDLE;
        endcase
`ifdef MCU_PIPE_TIMEOUT_EN
        // A handshake arriving in the final allowed cycle still wins.
        if (w_wait_state && (w_next == r_state) && (r_to_cnt >= TO_LAST))
            w_next = ERROR;
`endif
    end

    // -------------------------------------------------------------------------
    // State, counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= IDLE;
            r_settle        <= 1'b0;
            r_pix_cnt       <= '0;
            r_out_cnt       <= '0;
            r_win_cnt       <= '0;
            r_frame_windows <= FRAME_W'(1);
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the
            // pre-edge values of the counters regardless of statement order.
            r_state  <= w_next;
            r_settle <= w_in_settle && !r_settle;

            if (w_start) begin
                r_frame_windows <= (i_frame_windows == '0) ? FRAME_W'(1)
                                                           : i_frame_windows;
                r_pix_cnt <= '0;
                r_out_cnt <= '0;
                r_win_cnt <= '0;
            end else if (w_stop_exit) begin
                r_pix_cnt <= '0;
                r_out_cnt <= '0;
                r_win_cnt <= '0;
`ifdef MCU_PIPE_TIMEOUT_EN
            end else if ((r_state == ERROR) && i_stop) begin
                r_pix_cnt <= '0;
                r_out_cnt <= '0;
                r_win_cnt <= '0;
`endif
            end else begin
                if ((r_state == B1_SAVE) && (r_pix_cnt < FILL_V))
                    r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                else if (r_state == B2_SAVE)
                    r_pix_cnt <= '0;

                if (w_win_done)
                    r_out_cnt <= '0;
                else if ((r_state == WR_WAIT) && i_write_complete && (r_out_cnt < OUT_V))
                    r_out_cnt <= r_out_cnt + OUT_W'(1);

                if (w_win_done && (r_win_cnt < r_frame_windows))
                    r_win_cnt <= r_win_cnt + FRAME_W'(1);
            end
        end
    end

`ifdef MCU_PIPE_TIMEOUT_EN
    // Cycles spent in the current state; only advances in wait states.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_to_cnt <= '0;
        end else if (w_next != r_state) begin
            r_to_cnt <= '0;
        end else if (w_wait_state && (r_to_cnt < TO_LAST)) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Registered outputs: decoded from the current state, so each pulse
    // appears the cycle after its state is entered.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_inc_raddr       <= 1'b0;
            r_re              <= 1'b0;
            r_grayscale_start <= 1'b0;
            r_b1_save         <= 1'b0;
            r_b1_clear        <= 1'b0;
            r_gradient_start  <= 1'b0;
            r_b2_save         <= 1'b0;
            r_inc_waddr       <= 1'b0;
            r_we              <= 1'b0;
            r_busy            <= 1'b0;
            r_frame_done      <= 1'b0;
        end else begin
            r_inc_raddr       <= (r_state == RD_INC);
            r_re              <= (r_state == RD_EN);
            r_grayscale_start <= (r_state == GRAY_START);
            r_b1_save         <= (r_state == B1_SAVE);
            r_b1_clear        <= w_start || ((r_state == B2_SAVE) && NO_OVERLAP);
            r_gradient_start  <= (r_state == EDGE_START);
            r_b2_save         <= (r_state == B2_SAVE);
            r_inc_waddr       <= (r_state == WR_INC);
            r_we              <= (r_state == WR_EN);
            r_busy            <= (r_state != IDLE);
            r_frame_done      <= (r_state == FRAME_DONE);
        end
    end

`ifdef MCU_PIPE_TIMEOUT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_error <= 1'b0;
        else        r_error <= (r_state == ERROR);
    end
    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

    assign o_inc_raddr       = r_inc_raddr;
    assign o_re              = r_re;
    assign o_grayscale_start = r_grayscale_start;
    assign o_b1_save         = r_b1_save;
    assign o_b1_clear        = r_b1_clear;
    assign o_gradient_start  = r_gradient_start;
    assign o_b2_save         = r_b2_save;
    assign o_inc_waddr       = r_inc_waddr;
    assign o_we              = r_we;
    assign o_busy            = r_busy;
    assign o_frame_done      = r_frame_done;

endmodule

// File: tb/tb_mcu_pipe.sv
// -----------------------------------------------------------------------------
// tb_mcu_pipe -- self-checking bench for mcu_pipe.
// u_dut  : default parameters, handshakes individually controllable.
// u_dut2 : FILL_CNT=REFILL_CNT=4, OUT_CNT=3, handshakes tied high.
// u_dut3 : TIMEOUT_CYC=16 with i_waddr_ready stuck low (MCU_PIPE_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_mcu_pipe;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- u_dut ----------------
    logic        stop;
    logic [15:0] frame_windows;
    logic        raddr_ready, read_complete, gray_ready, grad_ready;
    logic        start_next_write, waddr_ready, write_complete;
    logic        inc_raddr, re, gs, b1_save, b1_clear, grad, b2_save;
    logic        inc_waddr, we, busy, frame_done, error;
    logic [11:0] outs1;
    assign outs1 = {inc_raddr, re, gs, b1_save, b1_clear, grad, b2_save,
                    inc_waddr, we, busy, frame_done, error};

    mcu_pipe u_dut (
        .clk(clk), .n_rst(n_rst), .i_stop(stop), .i_frame_windows(frame_windows),
        .i_raddr_ready(raddr_ready), .i_read_complete(read_complete),
        .i_grayscale_data_ready(gray_ready), .i_gradient_data_ready(grad_ready),
        .i_start_next_write(start_next_write), .i_waddr_ready(waddr_ready),
        .i_write_complete(write_complete),
        .o_inc_raddr(inc_raddr), .o_re(re), .o_grayscale_start(gs),
        .o_b1_save(b1_save), .o_b1_clear(b1_clear), .o_gradient_start(grad),
        .o_b2_save(b2_save), .o_inc_waddr(inc_waddr), .o_we(we),
        .o_busy(busy), .o_frame_done(frame_done), .o_error(error)
    );

    // ---------------- u_dut2 ----------------
    logic        s2_stop;
    logic [15:0] s2_fw;
    logic        d2_inc_raddr, d2_re, d2_gs, d2_b1_save, d2_b1_clear, d2_grad;
    logic        d2_b2_save, d2_inc_waddr, d2_we, d2_busy, d2_frame_done, d2_error;
    logic [11:0] outs2;
    assign outs2 = {d2_inc_raddr, d2_re, d2_gs, d2_b1_save, d2_b1_clear, d2_grad,
                    d2_b2_save, d2_inc_waddr, d2_we, d2_busy, d2_frame_done, d2_error};

    mcu_pipe #(.FILL_CNT(4), .REFILL_CNT(4), .OUT_CNT(3)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .i_stop(s2_stop), .i_frame_windows(s2_fw),
        .i_raddr_ready(1'b1), .i_read_complete(1'b1),
        .i_grayscale_data_ready(1'b1), .i_gradient_data_ready(1'b1),
        .i_start_next_write(1'b1), .i_waddr_ready(1'b1), .i_write_complete(1'b1),
        .o_inc_raddr(d2_inc_raddr), .o_re(d2_re), .o_grayscale_start(d2_gs),
        .o_b1_save(d2_b1_save), .o_b1_clear(d2_b1_clear), .o_gradient_start(d2_grad),
        .o_b2_save(d2_b2_save), .o_inc_waddr(d2_inc_waddr), .o_we(d2_we),
        .o_busy(d2_busy), .o_frame_done(d2_frame_done), .o_error(d2_error)
    );

`ifdef MCU_PIPE_TIMEOUT_EN
    // ---------------- u_dut3 ----------------
    logic        s3_stop;
    logic [15:0] s3_fw;
    logic        d3_inc_raddr, d3_re, d3_gs, d3_b1_save, d3_b1_clear, d3_grad;
    logic        d3_b2_save, d3_inc_waddr, d3_we, d3_busy, d3_frame_done, d3_error;
    logic [11:0] outs3;
    assign outs3 = {d3_inc_raddr, d3_re, d3_gs, d3_b1_save, d3_b1_clear, d3_grad,
                    d3_b2_save, d3_inc_waddr, d3_we, d3_busy, d3_frame_done, d3_error};

    mcu_pipe #(.TIMEOUT_CYC(16)) u_dut3 (
        .clk(clk), .n_rst(n_rst), .i_stop(s3_stop), .i_frame_windows(s3_fw),
        .i_raddr_ready(1'b1), .i_read_complete(1'b1),
        .i_grayscale_data_ready(1'b1), .i_gradient_data_ready(1'b1),
        .i_start_next_write(1'b1), .i_waddr_ready(1'b0), .i_write_complete(1'b1),
        .o_inc_raddr(d3_inc_raddr), .o_re(d3_re), .o_grayscale_start(d3_gs),
        .o_b1_save(d3_b1_save), .o_b1_clear(d3_b1_clear), .o_gradient_start(d3_grad),
        .o_b2_save(d3_b2_save), .o_inc_waddr(d3_inc_waddr), .o_we(d3_we),
        .o_busy(d3_busy), .o_frame_done(d3_frame_done), .o_error(d3_error)
    );
`endif

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int inc_raddr, re, gs, b1_save, b1_clr, grad, b2_save, inc_waddr, we, fd;
        int re_first;   // o_re count at the first o_gradient_start
    } cnt_t;

    typedef struct {
        logic [15:0] fw;
        int re, grad, we, b1_clr, fd, re_first;
    } vec_t;

    // Runs one frame on u_dut with all handshakes high; counts every pulse.
    task automatic run_frame(input logic [15:0] fw, output cnt_t c, output bit done);
        c = '{default: 0};
        done = 1'b0;
        frame_windows = fw;
        @(negedge clk);
        stop = 1'b0;
        for (int k = 0; k < 3004; k++) begin
            @(negedge clk);
            if (inc_raddr) c.inc_raddr++;
            if (re)        c.re++;
            if (gs)        c.gs++;
            if (b1_save)   c.b1_save++;
            if (b1_clear)  c.b1_clr++;
            if (grad) begin
                if (c.grad == 0) c.re_first = c.re;
                c.grad++;
            end
            if (b2_save)   c.b2_save++;
            if (inc_waddr) c.inc_waddr++;
            if (we)        c.we++;
            if (frame_done) begin
                c.fd++;
                if (!done) begin
                    done = 1'b1;
                    stop = 1'b1;
                    k = 2998;   // a few more cycles to catch stray pulses
                end
            end
            if (k > 3000) break;
        end
        stop = 1'b1;
    endtask

    // Waits for o_frame_done on u_dut, then holds it idle.
    task automatic wait_frame_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                stop = 1'b1;
                break;
            end
        end
        stop = 1'b1;
    endtask

    vec_t vecs[4];
    cnt_t c;
    bit   ok;
    int   pulses, rd_pulses, fd_pulses, idx, last_we, fd_idx;
    int   n_b1s, n_b1c, n_b2s, n_incw, n_we, coincide;

    initial begin
        //               fw     re grad we clr fd first
        vecs[0] = '{16'd2,  12, 2,   2,  1,  1, 9};
        vecs[1] = '{16'd1,   9, 1,   1,  1,  1, 9};
        vecs[2] = '{16'd0,   9, 1,   1,  1,  1, 9};
        vecs[3] = '{16'd3,  15, 3,   3,  1,  1, 9};

        stop = 1'b1; frame_windows = 16'd1;
        raddr_ready = 1'b1; read_complete = 1'b1; gray_ready = 1'b1; grad_ready = 1'b1;
        start_next_write = 1'b1; waddr_ready = 1'b1; write_complete = 1'b1;
        s2_stop = 1'b1; s2_fw = 16'd1;
`ifdef MCU_PIPE_TIMEOUT_EN
        s3_stop = 1'b1; s3_fw = 16'd1;
`endif

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("reset outs dut", outs1, 0);
        check("reset outs dut2", outs2, 0);
`ifdef MCU_PIPE_TIMEOUT_EN
        check("reset outs dut3", outs3, 0);
`endif
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle with stop", outs1, 0);

        // ---- table: whole frames, handshakes high ----
        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].fw, c, ok);
            check($sformatf("v%0d frame_done seen", i), ok, 1);
            check($sformatf("v%0d re", i), c.re, vecs[i].re);
            check($sformatf("v%0d inc_raddr", i), c.inc_raddr, vecs[i].re);
            check($sformatf("v%0d grayscale_start", i), c.gs, vecs[i].re);
            check($sformatf("v%0d b1_save", i), c.b1_save, vecs[i].re);
            check($sformatf("v%0d gradient_start", i), c.grad, vecs[i].grad);
            check($sformatf("v%0d b2_save", i), c.b2_save, vecs[i].grad);
            check($sformatf("v%0d we", i), c.we, vecs[i].we);
            check($sformatf("v%0d inc_waddr", i), c.inc_waddr, vecs[i].we);
            check($sformatf("v%0d b1_clear", i), c.b1_clr, vecs[i].b1_clr);
            check($sformatf("v%0d frame_done", i), c.fd, vecs[i].fd);
            check($sformatf("v%0d re before first gradient", i), c.re_first, vecs[i].re_first);
            check($sformatf("v%0d busy after", i), busy, 0);
        end

        // ---- read_complete held low: FSM parks in RD_WAIT ----
        read_complete = 1'b0;
        frame_windows = 16'd1;
        @(negedge clk);
        stop = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (re) begin ok = 1'b1; break; end
        end
        check("rd_hold re seen", ok, 1);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (outs1[11:3] != 9'd0 || frame_done) pulses++;
        end
        check("rd_hold no pulses", pulses, 0);
        check("rd_hold busy", busy, 1);
        read_complete = 1'b1;
        @(negedge clk);
        check("rd_hold gs +1", gs, 0);
        @(negedge clk);
        check("rd_hold gs +2", gs, 1);
        wait_frame_done(1000, ok);
        check("rd_hold frame completes", ok, 1);
        repeat (3) @(negedge clk);

        // ---- stop during WR_WAIT of window 0 of 3 ----
        write_complete = 1'b0;
        frame_windows = 16'd3;
        @(negedge clk);
        stop = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (we) begin ok = 1'b1; break; end
        end
        check("stop we seen", ok, 1);
        stop = 1'b1;
        repeat (3) @(negedge clk);
        write_complete = 1'b1;
        fd_pulses = 0; rd_pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (frame_done) fd_pulses++;
            if (inc_raddr || re) rd_pulses++;
        end
        check("stop no frame_done", fd_pulses, 0);
        check("stop no new reads", rd_pulses, 0);
        check("stop busy low", busy, 0);
        stop = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (b1_clear) begin ok = 1'b1; break; end
        end
        check("restart b1_clear", ok, 1);
        wait_frame_done(1000, ok);
        check("restart frame completes", ok, 1);
        repeat (3) @(negedge clk);

        // ---- asynchronous reset during EDGE_WAIT ----
        grad_ready = 1'b0;
        frame_windows = 16'd1;
        @(negedge clk);
        stop = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (grad) begin ok = 1'b1; break; end
        end
        check("rst gradient_start seen", ok, 1);
        repeat (2) @(negedge clk);
        check("rst busy before", busy, 1);
        n_rst = 1'b0;
        #1;
        check("rst outputs cleared", outs1, 0);
        stop = 1'b1;
        grad_ready = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(16'd1, c, ok);
        check("rst restart frame_done", ok, 1);
        check("rst restart re before gradient", c.re_first, 9);
        check("rst restart re", c.re, 9);

        // ---- u_dut2: no overlap, three writes per window ----
        n_b1s = 0; n_b1c = 0; n_b2s = 0; n_incw = 0; n_we = 0; coincide = 0;
        last_we = -1; fd_idx = -1;
        @(negedge clk);
        s2_stop = 1'b0;
        for (idx = 0; idx < 1000; idx++) begin
            @(negedge clk);
            if (d2_b1_save)   n_b1s++;
            if (d2_b1_clear)  n_b1c++;
            if (d2_b2_save) begin
                n_b2s++;
                if (d2_b1_clear) coincide++;
            end
            if (d2_inc_waddr) n_incw++;
            if (d2_we) begin n_we++; last_we = idx; end
            if (d2_frame_done) begin fd_idx = idx; s2_stop = 1'b1; break; end
        end
        s2_stop = 1'b1;
        check("dut2 frame_done seen", (fd_idx >= 0), 1);
        check("dut2 b1_save", n_b1s, 4);
        check("dut2 b1_clear", n_b1c, 2);
        check("dut2 b2_save", n_b2s, 1);
        check("dut2 b1_clear with b2_save", coincide, 1);
        check("dut2 inc_waddr", n_incw, 3);
        check("dut2 we", n_we, 3);
        check("dut2 last we to frame_done", fd_idx - last_we, 4);
        repeat (3) @(negedge clk);
        check("dut2 idle after", d2_busy, 0);

`ifdef MCU_PIPE_TIMEOUT_EN
        // ---- u_dut3: watchdog in WR_AWAIT ----
        @(negedge clk);
        s3_stop = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (d3_inc_waddr) begin ok = 1'b1; break; end
        end
        check("wdog inc_waddr seen", ok, 1);
        idx = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (d3_error) begin idx = k; break; end
        end
        check("wdog error rise cycle", idx, 17);
        repeat (3) @(negedge clk);
        check("wdog error held", d3_error, 1);
        s3_stop = 1'b1;
        repeat (3) @(negedge clk);
        check("wdog error cleared", d3_error, 0);
        check("wdog busy cleared", d3_busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
